// File: rtl/prog_tick_counter.sv
// Programmable up/down tick counter with a prescaler and an IDLE/RUN/DONE control FSM.
// Terminal steps can wrap, saturate or stop the run (one-shot).
module prog_tick_counter #(
  parameter int CNT_W       = 5,
  parameter int DIV_W       = 26,
  parameter int DIV_DEFAULT = 100
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Dir,
  input  logic [1:0]       Mode,
  input  logic             Load,
  input  logic [CNT_W-1:0] LoadValue,
  input  logic [CNT_W-1:0] Modulus,
  input  logic [DIV_W-1:0] DivSel,
  output logic [CNT_W-1:0] Counter,
  output logic             Tick,
  output logic             Tc,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   pre_q, pre_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick_q, tick_d;
  logic               tc_q, tc_d;
  logic               terminal;

  always_comb begin
    terminal = Dir ? (cnt_q == '0) : (cnt_q >= Modulus);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start && !Stop) begin
          div_d   = DivSel;
          pre_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (Stop) begin
          pre_d   = '0;
          state_d = IDLE;
        end else if (pre_q == div_q) begin
          pre_d  = '0;
          tick_d = 1'b1;
          if (!terminal) begin
            cnt_d = Dir ? (cnt_q - CNT_W'(1)) : (cnt_q + CNT_W'(1));
          end else begin
            tc_d = 1'b1;
            unique case (Mode)
              2'b01:   cnt_d = cnt_q;
              2'b10:   state_d = DONE;
              default: cnt_d = Dir ? Modulus : '0;
            endcase
          end
        end else begin
          pre_d = pre_q + DIV_W'(1);
        end
      end
      DONE: begin
        if (Start && !Stop) begin
          cnt_d   = Dir ? Modulus : '0;
          div_d   = DivSel;
          pre_d   = '0;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Load wins over everything except reset and freezes the control state.
    if (Load) begin
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = LoadValue;
      pre_d   = '0;
      tick_d  = 1'b0;
      tc_d    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      div_q   <= DIV_W'(DIV_DEFAULT);
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign Counter = cnt_q;
  assign Tick    = tick_q;
  assign Tc      = tc_q;
  assign Busy    = (state_q == RUN);
  assign Done    = (state_q == DONE);

endmodule

// File: doc/prog_tick_counter.md
PROG_TICK_COUNTER -- requirements
Module: prog_tick_counter

Interface
REQ-001 Parameter CNT_W, default 5: counter width in bits.
REQ-002 Parameter DIV_W, default 26: prescaler width in bits.
REQ-003 Parameter DIV_DEFAULT, default 100: prescaler terminal value in force after reset.
REQ-004 CLOCK_50  in  1  system clock; all state SHALL update on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Start  in  1  level, sampled each cycle; begins a run.
REQ-007 Stop  in  1  level; ends a run.
REQ-008 Dir  in  1  count direction: 0 = up, 1 = down.
REQ-009 Mode  in  2  end-of-range behaviour: 00 = wrap, 01 = saturate, 10 = one-shot, 11 = wrap.
REQ-010 Load  in  1  synchronous load strobe.
REQ-011 LoadValue  in  CNT_W  value written to Counter on Load.
REQ-012 Modulus  in  CNT_W  upper count limit (inclusive).
REQ-013 DivSel  in  DIV_W  prescaler terminal value, latched on Start.
REQ-014 Counter  out  CNT_W  current count, registered.
REQ-015 Tick  out  1  one-cycle pulse, asserted in the cycle Counter takes its stepped value.
REQ-016 Tc  out  1  one-cycle terminal-count pulse.
REQ-017 Busy  out  1  high while in state RUN.
REQ-018 Done  out  1  high while in state DONE.

Function
REQ-019 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-020 In IDLE, Start=1 and Stop=0 SHALL latch DivSel into the divisor register, clear the prescaler and enter RUN; Counter SHALL hold.
REQ-021 In RUN, the prescaler SHALL increment every cycle; when the prescaler equals the latched divisor it SHALL return to 0 and one step SHALL occur, giving a step period of divisor+1 cycles (divisor 0 gives a step every cycle).
REQ-022 Up step: if Counter >= Modulus, the step SHALL be terminal; otherwise Counter SHALL become Counter+1.
REQ-023 Down step: if Counter == 0, the step SHALL be terminal; otherwise Counter SHALL become Counter-1.
REQ-024 Terminal step: in wrap mode Counter SHALL become 0 (up) or Modulus (down); in saturate mode Counter SHALL hold; in one-shot mode Counter SHALL hold and the FSM SHALL enter DONE.
REQ-025 Tc SHALL pulse with Tick on every terminal step, including repeated terminal steps in saturate mode.
REQ-026 Stop=1 in RUN SHALL return the FSM to IDLE next cycle, with Counter holding its value and the prescaler cleared; Stop SHALL take priority over Start.
REQ-027 In DONE, Start=1 and Stop=0 SHALL set Counter to 0 (Dir=0) or Modulus (Dir=1), re-latch DivSel, clear the prescaler and enter RUN.
REQ-028 Load=1 in any state SHALL set Counter to LoadValue and clear the prescaler; Load SHALL override a coincident step, and no Tick or Tc SHALL be generated that cycle; the FSM state SHALL be unchanged.
REQ-029 Changes to Dir, Mode and Modulus during RUN SHALL take effect at the next step; a change to DivSel SHALL take effect only at the next Start.
REQ-030 Counter arithmetic SHALL be modulo 2^CNT_W and SHALL never be driven outside the range [0, 2^CNT_W-1].

Reset
REQ-031 Reset=1 SHALL, on the next edge and in any state, force: FSM = IDLE, Counter = 0, prescaler = 0, divisor = DIV_DEFAULT, Tick = 0, Tc = 0, Busy = 0, Done = 0.
REQ-032 Reset SHALL take priority over Load, Start and Stop.

Verification
REQ-033 Wrap up: Mode=00, Dir=0, Modulus=5, DivSel=3, pulse Start -> Counter steps every 4 cycles through 0,1,2,3,4,5,0; Tc pulses only on the 5->0 step.
REQ-034 Saturate down: Load with LoadValue=2, Mode=01, Dir=1, DivSel=1, Start -> Counter goes 2,1,0,0,0 at 2-cycle intervals; Tc pulses on each step at 0.
REQ-035 One-shot: Mode=10, Dir=0, Modulus=3, DivSel=0 -> Counter goes 0,1,2,3; the next step pulses Tc, Done=1, Busy=0, Counter holds 3; Start then gives Counter=0 and Busy=1.
REQ-036 Load collision: assert Load with LoadValue=9 on the same cycle a step is due -> Counter=9 with no Tick; the next Tick follows DivSel+1 cycles later.
REQ-037 Control priority: Start and Stop together in IDLE -> FSM stays IDLE; Stop in RUN -> IDLE with Counter held; Reset mid-RUN -> all outputs 0 on the next cycle.
REQ-038 Out of range: load Counter=7 with Modulus=4, Mode=00, Dir=0 -> the next step gives Counter=0 and Tc=1.
